regfile_bypass: RTL

Parametrised, clocked successor to the datapath register file. It holds `NUM_REGS` general registers of `DATA_W` bits and provides three combinational read ports (two operands, one store-data). Writes are synchronous, and a same-cycle write-to-read bypass removes decode/writeback hazards. The block also holds a registered CPSR and an auto-incrementing program-counter register. It sits between decode (read addresses) and writeback (`rd`/`wd`) in the core pipeline.

---
 rtl/regfile_bypass.sv | 76 +++++++
 1 files changed

// File: rtl/regfile_bypass.sv
// Register file with three combinational read ports, same-cycle write bypass,
// an auto-incrementing PC in the top register and a registered NZCV CPSR.
module regfile_bypass #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int RESET_INDEX = 1,
    parameter int PC_STEP     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rn,
    input  logic [ADDR_W-1:0] rm,
    input  logic [ADDR_W-1:0] str_src_reg,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] wd,
    input  logic              reg_write,
    input  logic              pc_inc,
    input  logic [3:0]        conditions_flags,
    input  logic              cpsr_write,
    output logic [DATA_W-1:0] s1,
    output logic [DATA_W-1:0] s2,
    output logic [DATA_W-1:0] data_to_mem,
    output logic [7:0]        cpsr
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int PC_IDX   = NUM_REGS - 1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [3:0]        r_flags;

    logic w_byp_rn;
    logic w_byp_rm;
    logic w_byp_str;

    // NOTE: the register array is reset explicitly because software relies on
    // the index-valued reset contents; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_write && rd == ADDR_W'(i)) begin
                    r_regs[i] <= wd;
                end else if (pc_inc && i == PC_IDX) begin
                    r_regs[i] <= r_regs[i] + DATA_W'(PC_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else if (cpsr_write) begin
            r_flags <= conditions_flags;
        end
    end

    // NOTE: bypass is gated by rst_n so a write pending under reset never leaks
    // onto the read ports; the PC increment deliberately has no bypass path.
    assign w_byp_rn  = rst_n && reg_write && (rn == rd);
    assign w_byp_rm  = rst_n && reg_write && (rm == rd);
    assign w_byp_str = rst_n && reg_write && (str_src_reg == rd);

    assign s1          = w_byp_rn  ? wd : r_regs[rn];
    assign s2          = w_byp_rm  ? wd : r_regs[rm];
    assign data_to_mem = w_byp_str ? wd : r_regs[str_src_reg];
    assign cpsr        = {r_flags, 4'b0000};

    a_rd_known: assert property (@(posedge clk) disable iff (!rst_n)
        reg_write |-> !$isunknown(rd));

endmodule
